// File: rtl/ay_bus_master_if.sv
// Command port and AY/YM bus pins of the Turbosound-FM bus initiator.
// The master modport is the initiator side; slave is the command source plus target pins.
interface ay_bus_master_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic [7:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic       BDIR;
    logic       BC;
    logic [7:0] BUS_DO;
    logic [7:0] BUS_DI;
    logic       RD_VALID;
    logic [7:0] RD_DATA;
    logic       ERR;
    logic       BUSY;

    modport master (
        input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, BUS_DI,
        output CMD_READY, BDIR, BC, BUS_DO, RD_VALID, RD_DATA, ERR, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, BUS_DI,
        input  CMD_READY, BDIR, BC, BUS_DO, RD_VALID, RD_DATA, ERR, BUSY
    );
endinterface

// File: rtl/ay_bus_master.sv
// Queued command stream to AY/YM BDIR/BC bus phases, each phase long enough for a
// two-flop synchroniser plus BDIR edge detector at the target.
//
// state | meaning
// IDLE  | waiting for FIFO entry; pop and decode
// ADDR  | address latch, BDIR=1 BC=1
// GAP1  | bus inactive after address
// DATA  | write strobe, BDIR=1 BC=0
// RDPH  | read strobe, BDIR=0 BC=1, BUS_DI captured on last cycle
// GAP2  | bus inactive after data/read
module ay_bus_master #(
    parameter int unsigned PHASE_CYC  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_s,
    ay_bus_master_if.master bus
);
    localparam int unsigned  AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]   PHASE_LD  = 8'(PHASE_CYC);
    localparam logic [AW:0]  FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]  CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
    localparam logic [1:0]   OP_WR     = 2'b00;
    localparam logic [1:0]   OP_RD     = 2'b01;
    localparam logic [1:0]   OP_CTL    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_DATA, S_RDPH, S_GAP2
    } state_t;

    logic [17:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [1:0]    head_op;
    logic [7:0]    head_addr, head_data;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic       bdir_q, bdir_d, bc_q, bc_d;
    logic [7:0] do_q, do_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    // READY comes from the registered count, so a same-cycle pop never admits a push into a full FIFO
    assign push = bus.CMD_VALID & ready_q;
    assign {head_op, head_addr, head_data} = fifo_mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.CMD_OP, bus.CMD_ADDR, bus.CMD_DATA};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_d     = data_q;
        bdir_d     = bdir_q;
        bc_d       = bc_q;
        do_d       = do_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        if (state_q != S_IDLE) cnt_d = cnt_q - 8'd1;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop    = 1'b1;
                    op_d   = head_op;
                    data_d = head_data;
                    // Write addresses 0xF8-0xFF would alias a control byte on the bus
                    if (head_op == 2'b11 || (head_op == OP_WR && head_addr[7:3] == 5'b11111)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                        cnt_d   = PHASE_LD;
                        bdir_d  = 1'b1;
                        bc_d    = 1'b1;
                        do_d    = (head_op == OP_CTL) ? {5'b11111, head_data[2:0]} : head_addr;
                    end
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_GAP1;
                    cnt_d   = PHASE_LD;
                    bdir_d  = 1'b0;
                    bc_d    = 1'b0;
                end
            end
            S_GAP1: begin
                if (cnt_q == 8'd1) begin
                    cnt_d = PHASE_LD;
                    if (op_q == OP_WR) begin
                        state_d = S_DATA;
                        bdir_d  = 1'b1;
                        do_d    = data_q;
                    end else if (op_q == OP_RD) begin
                        state_d = S_RDPH;
                        bc_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_GAP2;
                    cnt_d   = PHASE_LD;
                    bdir_d  = 1'b0;
                end
            end
            S_RDPH: begin
                if (cnt_q == 8'd1) begin
                    state_d    = S_GAP2;
                    cnt_d      = PHASE_LD;
                    bc_d       = 1'b0;
                    rd_data_d  = bus.BUS_DI;
                    rd_valid_d = 1'b1;
                end
            end
            S_GAP2: begin
                if (cnt_q == 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        busy_d  = (count_d != '0) || (state_d != S_IDLE);
        ready_d = (count_d != FIFO_FULL);
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            data_q     <= '0;
            bdir_q     <= 1'b0;
            bc_q       <= 1'b0;
            do_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_q     <= data_d;
            bdir_q     <= bdir_d;
            bc_q       <= bc_d;
            do_q       <= do_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.CMD_READY = ready_q;
    assign bus.BDIR      = bdir_q;
    assign bus.BC        = bc_q;
    assign bus.BUS_DO    = do_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.ERR       = err_q;
    assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: directed commands push expected bus phases and read data
// into queues; a negedge monitor reconstructs phases from BDIR/BC and compares.
module tb_ay_bus_master;
    logic CLK = 1'b0;
    logic RESET_s = 1'b1;
    ay_bus_master_if bif ();

    ay_bus_master #(.PHASE_CYC(4), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET_s(RESET_s), .bus(bif)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] code;
        logic [7:0] dout;
        int         len;
    } seg_t;

    seg_t       exp_q[$];
    logic [7:0] rd_q[$];
    int checks = 0;
    int errors = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: rebuilds bus phases from BDIR/BC and scores them against the queues
    logic [1:0] cur_code = 2'b00;
    int         cur_len = 0;
    logic [7:0] cur_do = 8'h00;
    bit         seen_act = 1'b0;

    always @(negedge CLK) begin
        logic [1:0] code;
        seg_t e;
        code = {bif.BDIR, bif.BC};
        if (RESET_s) begin
            cur_code = 2'b00;
            cur_len  = 0;
            seen_act = 1'b0;
        end else begin
            if (bif.ERR) err_cnt++;
            if (bif.RD_VALID) begin
                if (rd_q.size() == 0) fail_now("rd_valid_unexpected");
                else check("rd_data", {24'h0, bif.RD_DATA}, {24'h0, rd_q.pop_front()});
            end
            if (code == cur_code) begin
                cur_len++;
                if (code != 2'b00) check("bus_do_stable", {24'h0, bif.BUS_DO}, {24'h0, cur_do});
            end else begin
                if (cur_code != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        fail_now("phase_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("phase code/do/len", {14'h0, cur_code, cur_do, cur_len[7:0]},
                              {14'h0, e.code, e.dout, e.len[7:0]});
                    end
                end else if (seen_act && code != 2'b00) begin
                    check("gap_min", {31'h0, cur_len >= 4}, 32'h1);
                end
                if (code != 2'b00) seen_act = 1'b1;
                cur_code = code;
                cur_len  = 1;
                cur_do   = bif.BUS_DO;
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the command
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data);
        bit done = 1'b0;
        int n = 0;
        bif.CMD_VALID = 1'b1;
        bif.CMD_OP    = op;
        bif.CMD_ADDR  = addr;
        bif.CMD_DATA  = data;
        while (!done) begin
            @(negedge CLK);
            if (bif.CMD_READY) done = 1'b1;
            @(posedge CLK);
            #1;
            n++;
            if (!done && n >= 200) begin
                fail_now("cmd_accept_timeout");
                done = 1'b1;
            end
        end
        bif.CMD_VALID = 1'b0;
    endtask

    task automatic exp_write(input logic [7:0] addr, input logic [7:0] data);
        exp_q.push_back('{2'b11, addr, 4});
        exp_q.push_back('{2'b10, data, 4});
    endtask

    // First-command latency and total occupancy measured from the BDIR rise to BUSY low
    task automatic timed_run(input string name, input int req_len);
        int n = 0;
        @(negedge CLK);
        check({name, "_bdir_T1"}, {31'h0, bif.BDIR}, 32'h0);
        check({name, "_busy_T1"}, {31'h0, bif.BUSY}, 32'h1);
        @(negedge CLK);
        check({name, "_bdir_T2"}, {31'h0, bif.BDIR}, 32'h1);
        while (bif.BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_len"}, n, req_len);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bif.BUSY || bif.CMD_VALID) && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 1000) fail_now({name, "_idle_timeout"});
    endtask

    initial begin
        int n;
        bif.CMD_VALID = 1'b0;
        bif.CMD_OP    = 2'b00;
        bif.CMD_ADDR  = 8'h00;
        bif.CMD_DATA  = 8'h00;
        bif.BUS_DI    = 8'hA5;

        #12;
        check("rst_bdir",     {31'h0, bif.BDIR},      32'h0);
        check("rst_bc",       {31'h0, bif.BC},        32'h0);
        check("rst_bus_do",   {24'h0, bif.BUS_DO},    32'h0);
        check("rst_ready",    {31'h0, bif.CMD_READY}, 32'h1);
        check("rst_rd_valid", {31'h0, bif.RD_VALID},  32'h0);
        check("rst_rd_data",  {24'h0, bif.RD_DATA},   32'h0);
        check("rst_err",      {31'h0, bif.ERR},       32'h0);
        check("rst_busy",     {31'h0, bif.BUSY},      32'h0);
        @(posedge CLK);
        #1;
        RESET_s = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        exp_write(8'h07, 8'h38);
        send_cmd(2'b00, 8'h07, 8'h38);
        timed_run("write", 16);

        exp_q.push_back('{2'b11, 8'hFD, 4});
        send_cmd(2'b10, 8'h00, 8'h05);
        timed_run("ctrl", 8);

        exp_q.push_back('{2'b11, 8'h0E, 4});
        exp_q.push_back('{2'b01, 8'h0E, 4});
        rd_q.push_back(8'hA5);
        send_cmd(2'b01, 8'h0E, 8'h00);
        timed_run("read", 16);
        bif.BUS_DI = 8'h3C;
        repeat (5) @(posedge CLK);
        #1;
        check("rd_data_hold", {24'h0, bif.RD_DATA}, 32'hA5);

        // The first command leaves the FIFO one cycle after entering it, so the
        // fifth back-to-back push is the one that fills the four entries.
        for (int i = 1; i <= 5; i++) begin
            exp_write(8'(i), 8'(i * 16));
            send_cmd(2'b00, 8'(i), 8'(i * 16));
            check($sformatf("ready_after_acc%0d", i), {31'h0, bif.CMD_READY}, {31'h0, i < 5});
        end
        n = 0;
        while (!bif.CMD_READY && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("ready_returns", {31'h0, bif.CMD_READY}, 32'h1);
        wait_idle("b2b");

        send_cmd(2'b00, 8'hF9, 8'h12);
        repeat (6) @(posedge CLK);
        #1;
        check("err_alias_write", err_cnt, 1);
        send_cmd(2'b11, 8'h01, 8'h02);
        repeat (6) @(posedge CLK);
        #1;
        check("err_reserved_op", err_cnt, 2);
        check("err_busy", {31'h0, bif.BUSY}, 32'h0);

        exp_write(8'h02, 8'h11);
        exp_write(8'h03, 8'h22);
        send_cmd(2'b00, 8'h02, 8'h11);
        send_cmd(2'b00, 8'h03, 8'h22);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(bif.BDIR && !bif.BC && bif.BUS_DO == 8'h11) && n < 100);
        if (n >= 100) fail_now("data_phase_timeout");
        @(posedge CLK);
        #1;
        RESET_s = 1'b1;
        #1;
        check("arst_bdir",     {31'h0, bif.BDIR},     32'h0);
        check("arst_bc",       {31'h0, bif.BC},       32'h0);
        check("arst_bus_do",   {24'h0, bif.BUS_DO},   32'h0);
        check("arst_rd_valid", {31'h0, bif.RD_VALID}, 32'h0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RESET_s = 1'b0;
        repeat (10) @(negedge CLK);
        check("post_rst_busy",  {31'h0, bif.BUSY},      32'h0);
        check("post_rst_ready", {31'h0, bif.CMD_READY}, 32'h1);
        check("post_rst_bdir",  {31'h0, bif.BDIR},      32'h0);
        @(posedge CLK);
        #1;
        exp_write(8'h0A, 8'h5A);
        send_cmd(2'b00, 8'h0A, 8'h5A);
        timed_run("post_rst_write", 16);
        repeat (3) @(posedge CLK);
        #1;

        check("exp_phases_drained", exp_q.size(), 0);
        check("exp_reads_drained",  rd_q.size(),  0);
        check("err_total",          err_cnt,      2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
